// File: rtl/pim_dma_ctrl.sv
// rtl/pim_dma_ctrl.sv - word-at-a-time DMA sequencer between data memory and a PIM bank
// Optional cycle counter on o_perf_cycles enabled by `define PIM_DMA_PERF_EN.
module pim_dma_ctrl #(
  parameter int MEM_AW = 32,
  parameter int PIM_AW = 11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_dma_en,
  input  logic [2:0]        i_dma_funct3,
  input  logic [3:0]        i_dma_sel_pim,
  input  logic [12:0]       i_dma_size,
  input  logic [MEM_AW-1:0] i_dma_mem_addr,
  output logic              o_dma_busy,
  output logic              o_dma_done,
  output logic              o_dma_err,
  output logic              o_req,
  input  logic              i_gnt,
  output logic [MEM_AW-1:0] o_addr,
  output logic [31:0]       o_wr_data,
  output logic [3:0]        o_size,
  output logic              o_read,
  output logic              o_write,
  input  logic [31:0]       i_rd_data,
  output logic [3:0]        o_pim_sel,
  output logic [PIM_AW-1:0] o_pim_addr,
  output logic              o_pim_wr_en,
  output logic [31:0]       o_pim_wr_data,
  output logic              o_pim_rd_en,
  input  logic [31:0]       i_pim_rd_data,
  output logic [31:0]       o_perf_cycles
);

  typedef enum logic [2:0] {IDLE, M_REQ, M_DATA, P_RD, P_CAP, M_WR} state_t;

  localparam logic [MEM_AW-1:0] ADDR_STEP  = MEM_AW'(4);
  localparam logic [MEM_AW-1:0] ALIGN_MASK = ~MEM_AW'(3);
  localparam logic [PIM_AW-1:0] PIM_STEP   = PIM_AW'(1);

  state_t            state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [PIM_AW-1:0] pim_addr_q, pim_addr_d;
  logic [13:0]       rem_q, rem_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       buf_q, buf_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [13:0]       words;
  logic              cmd_legal;
  logic              cmd_accept;
  logic              last_word;

  always_comb begin
    words      = (14'(i_dma_size) + 14'd3) >> 2;
    cmd_legal  = (i_dma_funct3[2:1] == 2'b00);
    cmd_accept = (state_q == IDLE) && i_dma_en && cmd_legal && (words != 14'd0);
    last_word  = (rem_q == 14'd1);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pim_addr_d = pim_addr_q;
    rem_d      = rem_q;
    sel_d      = sel_q;
    buf_d      = buf_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_dma_en) begin
          if (!cmd_legal) begin
            err_d = 1'b1;
          end else if (words == 14'd0) begin
            done_d = 1'b1;
          end else begin
            sel_d      = i_dma_sel_pim;
            addr_d     = i_dma_mem_addr & ALIGN_MASK;
            pim_addr_d = '0;
            rem_d      = words;
            state_d    = i_dma_funct3[0] ? P_RD : M_REQ;
          end
        end
      end
      M_REQ: begin
        if (i_gnt) state_d = M_DATA;
      end
      M_DATA: begin
        addr_d     = addr_q + ADDR_STEP;
        pim_addr_d = pim_addr_q + PIM_STEP;
        rem_d      = rem_q - 14'd1;
        state_d    = last_word ? IDLE : M_REQ;
        done_d     = last_word;
      end
      P_RD: state_d = P_CAP;
      P_CAP: begin
        buf_d   = i_pim_rd_data;
        state_d = M_WR;
      end
      M_WR: begin
        // Counters only move once the write has been accepted by the arbiter.
        if (i_gnt) begin
          addr_d     = addr_q + ADDR_STEP;
          pim_addr_d = pim_addr_q + PIM_STEP;
          rem_d      = rem_q - 14'd1;
          state_d    = last_word ? IDLE : P_RD;
          done_d     = last_word;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      pim_addr_q <= '0;
      rem_q      <= '0;
      sel_q      <= '0;
      buf_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pim_addr_q <= pim_addr_d;
      rem_q      <= rem_d;
      sel_q      <= sel_d;
      buf_q      <= buf_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_dma_busy    = (state_q != IDLE);
  assign o_dma_done    = done_q;
  assign o_dma_err     = err_q;
  assign o_req         = (state_q == M_REQ) || (state_q == M_WR);
  assign o_read        = (state_q == M_REQ);
  assign o_write       = (state_q == M_WR);
  assign o_size        = o_req ? 4'b1111 : 4'b0000;
  assign o_addr        = o_req ? addr_q : '0;
  assign o_wr_data     = o_write ? buf_q : '0;
  assign o_pim_sel     = o_dma_busy ? sel_q : 4'b0000;
  assign o_pim_addr    = pim_addr_q;
  assign o_pim_wr_en   = (state_q == M_DATA);
  assign o_pim_wr_data = o_pim_wr_en ? i_rd_data : '0;
  assign o_pim_rd_en   = (state_q == P_RD);

`ifdef PIM_DMA_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (cmd_accept) perf_d = '0;
    else if (o_dma_busy) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign o_perf_cycles = perf_q;
`else
  assign o_perf_cycles = '0;
`endif

endmodule

// File: tb/tb_pim_dma_ctrl.sv
// tb/tb_pim_dma_ctrl.sv - command-table bench with memory/PIM responder and op scoreboard
module tb_pim_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_en;
  logic [2:0]  dma_funct3;
  logic [3:0]  dma_sel;
  logic [12:0] dma_size;
  logic [31:0] dma_addr;
  logic        busy, done, err, req, gnt, rd, wr, pim_wr_en, pim_rd_en;
  logic [31:0] addr, wr_data, rd_data, pim_wr_data, pim_rd_data, perf;
  logic [3:0]  size, pim_sel;
  logic [10:0] pim_addr;

  always #5 clk = ~clk;

  pim_dma_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_dma_en(dma_en), .i_dma_funct3(dma_funct3),
    .i_dma_sel_pim(dma_sel), .i_dma_size(dma_size), .i_dma_mem_addr(dma_addr),
    .o_dma_busy(busy), .o_dma_done(done), .o_dma_err(err),
    .o_req(req), .i_gnt(gnt), .o_addr(addr), .o_wr_data(wr_data), .o_size(size),
    .o_read(rd), .o_write(wr), .i_rd_data(rd_data),
    .o_pim_sel(pim_sel), .o_pim_addr(pim_addr), .o_pim_wr_en(pim_wr_en),
    .o_pim_wr_data(pim_wr_data), .o_pim_rd_en(pim_rd_en), .i_pim_rd_data(pim_rd_data),
    .o_perf_cycles(perf)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [3:0]  sel;
    logic [12:0] size;
    logic [31:0] addr;
    int          wait_c;
    bit          stray;
    bit          poke;
    int          exp_busy;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  op_t         mem_q[$];
  op_t         pim_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          gnt_wait = 0;
  bit          stray_gnt = 0;
  int          wcnt = 0;
  logic [3:0]  cur_sel = '0;
  logic [31:0] last_perf = '0;
  vec_t        vecs[9];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] pim_fn(input logic [10:0] p);
    return 32'hBEEF_0000 + 32'(p) * 32'h11;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input vec_t v);
    int          nw;
    logic [31:0] a;
    op_t         o;
    nw = (int'(v.size) + 3) / 4;
    a  = v.addr & 32'hFFFF_FFFC;
    if (v.f3[2:1] != 2'b00) return;
    for (int i = 0; i < nw; i++) begin
      if (v.f3[0] == 1'b0) begin
        o = '{wr: 1'b0, addr: a, data: '0};                   mem_q.push_back(o);
        o = '{wr: 1'b1, addr: 32'(i), data: mem_fn(a)};      pim_q.push_back(o);
      end else begin
        o = '{wr: 1'b0, addr: 32'(i), data: '0};              pim_q.push_back(o);
        o = '{wr: 1'b1, addr: a, data: pim_fn(11'(i))};      mem_q.push_back(o);
      end
      a = a + 32'd4;
    end
  endtask

  // Memory/PIM responder: checks every request against the scoreboard head
  always @(negedge clk) begin
    op_t e;
    if (rst) begin
      wcnt = 0;
      gnt  = 1'b0;
    end else begin
      chk("o_size", {28'd0, size}, req ? 32'hF : 32'h0);
      chk("o_pim_sel", {28'd0, pim_sel}, busy ? {28'd0, cur_sel} : 32'h0);
      if (req) begin
        chk("req_without_expected_op", 32'(mem_q.size() == 0), 32'd0);
        if (mem_q.size() != 0) begin
          e = mem_q[0];
          chk("o_addr", addr, e.addr);
          chk("o_write", {31'd0, wr}, {31'd0, e.wr});
          chk("o_read", {31'd0, rd}, {31'd0, !e.wr});
          if (e.wr) chk("o_wr_data", wr_data, e.data);
          if (wcnt == gnt_wait) begin
            gnt  = 1'b1;
            wcnt = 0;
            void'(mem_q.pop_front());
            if (!e.wr) rd_data = mem_fn(e.addr);
          end else begin
            gnt  = 1'b0;
            wcnt = wcnt + 1;
          end
        end
      end else begin
        gnt = stray_gnt;
      end
      if (pim_wr_en || pim_rd_en) begin
        chk("pim_op_without_expected", 32'(pim_q.size() == 0), 32'd0);
        if (pim_q.size() != 0) begin
          e = pim_q.pop_front();
          chk("pim_op_kind", {31'd0, pim_wr_en}, {31'd0, e.wr});
          chk("o_pim_addr", 32'(pim_addr), e.addr);
          if (e.wr) chk("o_pim_wr_data", pim_wr_data, e.data);
        end
        if (pim_rd_en) pim_rd_data = pim_fn(pim_addr);
      end
    end
  end

  task automatic drive_cmd(input vec_t v);
    gnt_wait   = v.wait_c;
    stray_gnt  = v.stray;
    cur_sel    = v.sel;
    push_exp(v);
    dma_funct3 = v.f3;
    dma_sel    = v.sel;
    dma_size   = v.size;
    dma_addr   = v.addr;
    dma_en     = 1'b1;
    @(negedge clk);
    dma_en     = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int busy_cnt;
    bit ended;
    busy_cnt = 0;
    ended    = 0;
    @(negedge clk);
    drive_cmd(v);
    for (int c = 0; c < 400; c++) begin
      if (done || err) begin
        ended = 1;
        break;
      end
      busy_cnt += int'(busy);
      if (v.poke) begin
        if (c == 2) begin
          dma_en = 1'b1; dma_funct3 = 3'b010;
        end else if (c == 3) begin
          dma_funct3 = 3'b001; dma_size = 13'd4;
        end else if (c == 4) begin
          dma_en = 1'b0;
        end
      end
      @(negedge clk);
    end
    chk("timeout", {31'd0, !ended}, 32'd0);
    chk("done_pulse", {31'd0, done}, {31'd0, v.exp_done});
    chk("err_pulse", {31'd0, err}, {31'd0, v.exp_err});
    chk("busy_at_end", {31'd0, busy}, 32'd0);
    chk("busy_cycles", busy_cnt, v.exp_busy);
    chk("mem_ops_left", 32'(mem_q.size()), 32'd0);
    chk("pim_ops_left", 32'(pim_q.size()), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("err_one_cycle", {31'd0, err}, 32'd0);
    if (v.exp_busy > 0) last_perf = 32'(v.exp_busy);
`ifdef PIM_DMA_PERF_EN
    chk("perf_cycles", perf, last_perf);
`else
    chk("perf_cycles", perf, 32'd0);
`endif
  endtask

  initial begin
    vec_t r;
    bit   found;
    //          f3      sel      size    addr          wait stray poke busy done err
    vecs[0] = '{3'b000, 4'b0010, 13'd16, 32'h1000_0003, 0,  0,    0,   8,   1,   0};
    vecs[1] = '{3'b001, 4'b0100, 13'd5,  32'h2000_0008, 3,  1,    0,   12,  1,   0};
    vecs[2] = '{3'b000, 4'b0001, 13'd0,  32'h0000_1000, 0,  0,    0,   0,   1,   0};
    vecs[3] = '{3'b010, 4'b0001, 13'd16, 32'h0000_1000, 0,  0,    0,   0,   0,   1};
    vecs[4] = '{3'b000, 4'b1000, 13'd8,  32'hFFFF_FFFC, 0,  0,    0,   4,   1,   0};
    vecs[5] = '{3'b001, 4'b0001, 13'd1,  32'h0000_0040, 0,  0,    0,   3,   1,   0};
    vecs[6] = '{3'b000, 4'b0001, 13'd7,  32'h0000_0100, 2,  1,    1,   8,   1,   0};
    vecs[7] = '{3'b111, 4'b0010, 13'd0,  32'h0000_0000, 0,  0,    0,   0,   0,   1};
    vecs[8] = '{3'b001, 4'b1000, 13'd13, 32'h3000_0002, 1,  0,    0,   16,  1,   0};

    rst = 1'b1; dma_en = 1'b0; dma_funct3 = '0; dma_sel = '0; dma_size = '0; dma_addr = '0;
    rd_data = '0; pim_rd_data = '0; gnt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_pim_sel", {28'd0, pim_sel}, 32'd0);
    chk("rst_pim_addr", 32'(pim_addr), 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_perf", perf, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Abort a 3-word store while word 2 waits for its grant
    r = '{3'b001, 4'b0100, 13'd12, 32'h5000_0000, 3, 0, 0, 0, 0, 0};
    @(negedge clk);
    drive_cmd(r);
    found = 0;
    for (int c = 0; c < 100; c++) begin
      if (wr && pim_addr == 11'd1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("reached_word2_write", {31'd0, found}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_mem", {29'd0, req, rd, wr}, 32'd0);
    chk("abort_size", {28'd0, size}, 32'd0);
    chk("abort_addr", addr, 32'd0);
    chk("abort_wr_data", wr_data, 32'd0);
    chk("abort_pim", {29'd0, pim_wr_en, pim_rd_en, |pim_sel}, 32'd0);
    chk("abort_pim_addr", 32'(pim_addr), 32'd0);
    chk("abort_pim_wr_data", pim_wr_data, 32'd0);
    chk("abort_perf", perf, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", {30'd0, done, err}, 32'd0);
    end
    mem_q.delete();
    pim_q.delete();
    last_perf = '0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_abort_no_done", {30'd0, done, err}, 32'd0);
    r = '{3'b000, 4'b0001, 13'd4, 32'h0000_0060, 0, 0, 0, 2, 1, 0};
    run_vec(r);
    r = '{3'b000, 4'b0010, 13'd16, 32'h0000_0200, 0, 0, 0, 8, 1, 0};
    run_vec(r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pim_dma_ctrl.md
# pim_dma_ctrl

Sequencer for PIM-bank DMA transfers launched by the core's DMA instruction. It latches one command (direction, one-hot PIM select, byte size, memory address) and moves 32-bit words one at a time between data memory (request/grant master port) and the selected PIM bank (1-cycle-latency SRAM-style port). It holds `o_dma_busy` so the core pipeline stalls until the transfer completes. It sits beside the core, sharing the data-memory arbiter with the core's load/store port.

## Interface
- `MEM_AW`, 32, memory address width
- `PIM_AW`, 11, PIM word-address width (2048 words = 8 KB max)
- `i_clk`  in  1  clock
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_dma_en`  in  1  command strobe (single cycle)
- `i_dma_funct3`  in  3  direction: 3'b000 mem→PIM, 3'b001 PIM→mem, others illegal
- `i_dma_sel_pim`  in  4  one-hot PIM bank select
- `i_dma_size`  in  13  transfer size in bytes
- `i_dma_mem_addr`  in  32  memory start address
- `o_dma_busy`  out  1  transfer in progress
- `o_dma_done`  out  1  one-cycle pulse at completion
- `o_dma_err`  out  1  one-cycle pulse on illegal command
- `o_req`  out  1  memory request
- `i_gnt`  in  1  memory grant
- `o_addr`  out  32  memory word address
- `o_wr_data`  out  32  memory write data
- `o_size`  out  4  byte enables, always 4'b1111 while `o_req`, else 0
- `o_read` / `o_write`  out  1 each  access type, valid with `o_req`
- `i_rd_data`  in  32  memory read data, valid the cycle after a granted read
- `o_pim_sel`  out  4  latched bank select, 0 when idle
- `o_pim_addr`  out  `PIM_AW`  PIM word address
- `o_pim_wr_en`  out  1  PIM write strobe
- `o_pim_wr_data`  out  32  PIM write data
- `o_pim_rd_en`  out  1  PIM read strobe
- `i_pim_rd_data`  in  32  PIM read data, valid the cycle after `o_pim_rd_en`

## Operation
- Word count: `words = (i_dma_size + 3) >> 2` (14-bit). Memory address is forced word-aligned (`[1:0]` = 0). PIM address starts at 0.
- States: IDLE, M_REQ, M_DATA (load); P_RD, P_CAP, M_WR (store).
- IDLE:
  - On `i_dma_en` with funct3 000/001 and `words` > 0: latch the command, then go to M_REQ (000) or P_RD (001).
  - With `words` = 0: stay in IDLE and pulse `o_dma_done` next cycle.
  - With illegal funct3: stay in IDLE and pulse `o_dma_err` next cycle.
- Load path:
  - M_REQ: assert `o_req` and `o_read` with `o_addr`; hold until `i_gnt`, then go to M_DATA.
  - M_DATA: drive `o_pim_wr_en` = 1 with `o_pim_wr_data = i_rd_data`. Then advance: addr += 4, pim_addr += 1, remaining −= 1. If remaining was 1, go to IDLE and pulse done; otherwise go to M_REQ.
- Store path:
  - P_RD: assert `o_pim_rd_en`, then go to P_CAP.
  - P_CAP: capture `i_pim_rd_data` into the buffer, then go to M_WR.
  - M_WR: assert `o_req` and `o_write` with `o_wr_data` = buffer; hold until `i_gnt`. Then advance the counters and go to P_RD, or to IDLE with done.
- `o_dma_busy = (state != IDLE)`.
- `i_dma_en` while busy is ignored (the core cannot issue one while stalled).
- Memory address wraps modulo 2^32. PIM address cannot overflow: max 2048 words.
- `i_gnt` outside a request state is ignored.

## Timing
- All outputs registered or decoded from state.
- Reset values: every output is 0 and state is IDLE.
- Reset mid-transfer aborts immediately: no done pulse, counters cleared.
- `o_dma_busy` rises the cycle after `i_dma_en`, which satisfies the core's stall = busy || ex.dma_en.
- Load: 2 cycles/word at zero grant wait. Store: 3 cycles/word. Each cycle of grant wait adds one.
- `o_dma_done` is high in the first IDLE cycle after the last word; `o_dma_busy` is low in that same cycle.
- `o_req` stays high and address/data stay stable until the cycle `i_gnt` is sampled high.

## Configuration
- `PIM_DMA_PERF_EN` defined:
  - Adds output `o_perf_cycles` [31:0].
  - Cleared on command accept, incremented every busy cycle, and held after completion until the next accept.
- Undefined: the port exists but is tied to 0 and the counter logic is removed.

## Test plan
- Load, funct3 000, sel 4'b0010, size 16, addr 0x1000_0003, `i_gnt` always 1 → reads at 0x1000_0000/04/08/0C; PIM writes to addr 0–3 with the read data; busy for 8 cycles; done pulse.
- Store, funct3 001, size 5 (2 words), `i_gnt` delayed 3 cycles per request → PIM reads 0,1; memory writes of the captured data with `o_size` 4'b1111; `o_req` held stable during the wait; busy 12 cycles.
- Size 0 → no `o_req`, busy never rises, done pulse 1 cycle after en. funct3 3'b010 → `o_dma_err` pulse, no busy.
- Address 0xFFFF_FFFC, size 8 → second access at 0x0000_0000.
- Assert `i_rst` during M_WR of word 2 → all outputs 0 immediately; no done; a new command after reset starts with PIM addr 0.
- With `PIM_DMA_PERF_EN`, 4-word load, zero wait → `o_perf_cycles` = 8 after done.
